// File: rtl/commit_unit_pkg.sv
// Shared constants, rob_info layout and state encoding for the commit stage.
// Optional feature macro: COMMIT_INSTRET_EN (retired-instruction counter).
package commit_unit_pkg;

  localparam int unsigned RNDEPTH   = 4;
  localparam int unsigned RN_W      = $clog2(RNDEPTH);
  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned PC_W      = 64;
  localparam int unsigned RD_W      = 5;
  localparam int unsigned WB_W      = ARCH_REGS * RNDEPTH;
  localparam int unsigned WB_IDX_W  = $clog2(WB_W);

  // rob_info bit offsets, LSB first
  localparam int unsigned RI_ILL_OFF = 0;
  localparam int unsigned RI_SU_OFF  = 1;
  localparam int unsigned RI_BR_OFF  = 2;
  localparam int unsigned RI_RN_OFF  = 3;
  localparam int unsigned RI_RD_OFF  = RI_RN_OFF + RN_W;
  localparam int unsigned RI_PC_OFF  = RI_RD_OFF + RD_W;
  localparam int unsigned ROB_INFO_W = RI_PC_OFF + PC_W;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [RD_W-1:0] rd0;
    logic [RN_W-1:0] rn;
    logic            is_branch;
    logic            is_su;
    logic            is_illegal;
  } rob_info_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    TRAP  = 2'd2
  } state_e;

  // Flat position of the written-back bit for (rd, rn)
  function automatic logic [WB_IDX_W-1:0] wb_index(input logic [RD_W-1:0] rd,
                                                   input logic [RN_W-1:0] rn);
    return WB_IDX_W'(RNDEPTH * 32'(rd) + 32'(rn));
  endfunction

endpackage

// File: rtl/commit_unit_if.sv
// Handshake and result bundle between the commit unit and its neighbours
// (reorder fifo, BRU, LSU, rename, trap handling).
interface commit_unit_if;
  import commit_unit_pkg::*;

  logic                  rob_vaild;
  logic                  rob_ready;
  logic [ROB_INFO_W-1:0] rob_info;
  logic [WB_W-1:0]       wbLog_qout;
  logic                  bru_vaild;
  logic                  bru_ready;
  logic                  bru_miss;
  logic [PC_W-1:0]       bru_target;
  logic                  su_commit_v;
  logic                  su_commit_ready;
  logic                  commit_abi_v;
  logic [RD_W-1:0]       commit_rd0;
  logic [RN_W-1:0]       commit_rn;
  logic                  flush;
  logic [PC_W-1:0]       flush_pc;
  logic                  excp_v;
  logic [PC_W-1:0]       excp_pc;
  logic                  trap_ack;

  modport master (
    input  rob_vaild, rob_info, wbLog_qout, bru_vaild, bru_miss, bru_target,
           su_commit_ready, trap_ack,
    output rob_ready, bru_ready, su_commit_v, commit_abi_v, commit_rd0, commit_rn,
           flush, flush_pc, excp_v, excp_pc
  );

  modport slave (
    output rob_vaild, rob_info, wbLog_qout, bru_vaild, bru_miss, bru_target,
           su_commit_ready, trap_ack,
    input  rob_ready, bru_ready, su_commit_v, commit_abi_v, commit_rd0, commit_rn,
           flush, flush_pc, excp_v, excp_pc
  );

endinterface

// File: rtl/commit_bru_hold.sv
// One-entry holding register for the branch resolution result; freed when its
// branch retires, and unconditionally emptied during a pipeline flush.
module commit_bru_hold
  import commit_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            bru_vaild,
  input  logic            bru_miss,
  input  logic [PC_W-1:0] bru_target,
  input  logic            clear,
  input  logic            kill,
  output logic            bru_ready,
  output logic            pend_v,
  output logic            pend_miss,
  output logic [PC_W-1:0] pend_target
);

  logic            pend_v_q;
  logic            miss_q;
  logic [PC_W-1:0] target_q;
  logic            capture;

  assign bru_ready   = ~pend_v_q & ~rst;
  assign capture     = bru_vaild & bru_ready;
  assign pend_v      = pend_v_q;
  assign pend_miss   = miss_q;
  assign pend_target = target_q;

  // kill beats capture so nothing from the squashed path survives a flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v_q <= 1'b0;
      miss_q   <= 1'b0;
      target_q <= '0;
    end else begin
      if (kill)         pend_v_q <= 1'b0;
      else if (capture) pend_v_q <= 1'b1;
      else if (clear)   pend_v_q <= 1'b0;
      if (capture) begin
        miss_q   <= bru_miss;
        target_q <= bru_target;
      end
    end
  end

endmodule

// File: rtl/commit_unit.sv
// In-order retirement from the reorder fifo head: rename publish, mispredict
// flush, illegal-instruction trap. Optional instret counter: COMMIT_INSTRET_EN.
module commit_unit
  import commit_unit_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  commit_unit_if.master bus
`ifdef COMMIT_INSTRET_EN
  ,
  output logic [63:0]  instret
`endif
);

  state_e          state_q, state_d;
  rob_info_t       head;
  logic            pend_v, pend_miss;
  logic [PC_W-1:0] pend_target;
  logic            complete, pop, su_req, wb_hit, retire_rd;

  logic            commit_abi_v_q;
  logic [RD_W-1:0] commit_rd0_q;
  logic [RN_W-1:0] commit_rn_q;
  logic [PC_W-1:0] flush_pc_q, excp_pc_q;

  assign head = rob_info_t'(bus.rob_info);

  commit_bru_hold u_bru_hold (
    .clk        (CLK),
    .rst        (RST),
    .bru_vaild  (bus.bru_vaild),
    .bru_miss   (bus.bru_miss),
    .bru_target (bus.bru_target),
    .clear      (pop & head.is_branch),
    .kill       (state_q == FLUSH),
    .bru_ready  (bus.bru_ready),
    .pend_v     (pend_v),
    .pend_miss  (pend_miss),
    .pend_target(pend_target)
  );

  // Head-complete decode, pop/store strobes and next state
  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    pop      = 1'b0;
    su_req   = 1'b0;
    wb_hit   = bus.wbLog_qout[wb_index(head.rd0, head.rn)];

    if (head.is_illegal)     complete = 1'b0;
    else if (head.is_branch) complete = pend_v;
    else if (head.is_su)     complete = bus.su_commit_ready;
    else                     complete = (head.rd0 == '0) | wb_hit;

    case (state_q)
      RUN: begin
        su_req = bus.rob_vaild & head.is_su & ~head.is_illegal;
        pop    = bus.rob_vaild & complete;
        if (bus.rob_vaild & head.is_illegal)      state_d = TRAP;
        else if (pop & head.is_branch & pend_miss) state_d = FLUSH;
      end
      FLUSH:   state_d = RUN;
      TRAP:    if (bus.trap_ack) state_d = FLUSH;
      default: state_d = RUN;
    endcase
  end

  // A mispredicted branch never publishes, keeping flush and commit_abi_v exclusive
  assign retire_rd = pop & (head.rd0 != '0) & ~head.is_su & ~(head.is_branch & pend_miss);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      commit_abi_v_q <= 1'b0;
      commit_rd0_q   <= '0;
      commit_rn_q    <= '0;
      flush_pc_q     <= '0;
      excp_pc_q      <= '0;
    end else begin
      commit_abi_v_q <= retire_rd;
      if (retire_rd) begin
        commit_rd0_q <= head.rd0;
        commit_rn_q  <= head.rn;
      end
      if (state_q == RUN && state_d == FLUSH)      flush_pc_q <= pend_target;
      else if (state_q == TRAP && bus.trap_ack)    flush_pc_q <= excp_pc_q;
      if (state_q == RUN && state_d == TRAP)       excp_pc_q  <= head.pc;
    end
  end

  assign bus.rob_ready    = pop & ~RST;
  assign bus.su_commit_v  = su_req & ~RST;
  assign bus.commit_abi_v = commit_abi_v_q;
  assign bus.commit_rd0   = commit_rd0_q;
  assign bus.commit_rn    = commit_rn_q;
  assign bus.flush        = (state_q == FLUSH);
  assign bus.flush_pc     = flush_pc_q;
  assign bus.excp_v       = (state_q == TRAP);
  assign bus.excp_pc      = excp_pc_q;

`ifdef COMMIT_INSTRET_EN
  logic [63:0] instret_q;

  // Free-running retire count; flushes do not touch it
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      instret_q <= '0;
    else if (pop) instret_q <= instret_q + 64'd1;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: vector table for the head-complete
// decode, hand sequences for stall, flush, trap and reset corners.
module tb_commit_unit;
  import commit_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  commit_unit_if bus();

`ifdef COMMIT_INSTRET_EN
  logic [63:0] instret;
  commit_unit dut (.CLK(clk), .RST(rst), .bus(bus), .instret(instret));
`else
  commit_unit dut (.CLK(clk), .RST(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rd;
    logic [1:0] rn;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic       vld;
    logic [4:0] rd;
    logic [1:0] rn;
    logic       br;
    logic       su;
    int         wb;      // 0 none, 1 matching bit, 2 neighbouring bit only
    logic       sur;
    logic       exp_ready;
    logic       exp_su;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ROB_INFO_W-1:0] mk(input logic [63:0] pc, input logic [4:0] rd,
                                               input logic [1:0] rn, input logic br,
                                               input logic su, input logic ill);
    rob_info_t r;
    r.pc = pc; r.rd0 = rd; r.rn = rn;
    r.is_branch = br; r.is_su = su; r.is_illegal = ill;
    return r;
  endfunction

  task automatic set_wb(input int mode, input logic [4:0] rd, input logic [1:0] rn);
    int idx;
    idx = int'(rd) * 4 + int'(rn);
    bus.wbLog_qout = '0;
    if (mode == 1) bus.wbLog_qout[idx] = 1'b1;
    if (mode == 2) bus.wbLog_qout[idx ^ 1] = 1'b1;
  endtask

  task automatic head(input logic vld, input logic [63:0] pc, input logic [4:0] rd,
                      input logic [1:0] rn, input logic br, input logic su, input logic ill);
    bus.rob_vaild = vld;
    bus.rob_info  = mk(pc, rd, rn, br, su, ill);
  endtask

  // Scoreboard side: every published rename mapping must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.commit_abi_v) begin
      exp_t e;
      checks++;
      if (bus.flush) begin
        errors++;
        $display("FAIL commit_vs_flush: flush=%0b with commit_abi_v=1", bus.flush);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit: got rd=%0d rn=%0d expected none",
                 bus.commit_rd0, bus.commit_rn);
      end else begin
        e = exp_q.pop_front();
        if (bus.commit_rd0 !== e.rd || bus.commit_rn !== e.rn) begin
          errors++;
          $display("FAIL commit_map: got rd=%0d rn=%0d expected rd=%0d rn=%0d",
                   bus.commit_rd0, bus.commit_rn, e.rd, e.rn);
        end
      end
    end
  end

  initial begin
    vecs[0]  = '{1'b0, 5'd5,  2'd2, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'd0,  2'd1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 5'd5,  2'd2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 5'd5,  2'd2, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 5'd5,  2'd2, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 5'd31, 2'd3, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 5'd1,  2'd0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 5'd7,  2'd0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 5'd7,  2'd0, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 5'd9,  2'd1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 5'd7,  2'd0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0};

    bus.wbLog_qout = '0; bus.bru_vaild = 1'b0; bus.bru_miss = 1'b0;
    bus.bru_target = '0; bus.trap_ack = 1'b0;
    // Head that would pop and request a store if reset did not gate it
    head(1'b1, 64'h40, 5'd3, 2'd0, 1'b0, 1'b1, 1'b0);
    bus.su_commit_ready = 1'b1;
    #3;
    chk("rst_rob_ready", bus.rob_ready, 0);
    chk("rst_su_commit_v", bus.su_commit_v, 0);
    chk("rst_bru_ready", bus.bru_ready, 0);
    chk("rst_commit_abi_v", bus.commit_abi_v, 0);
    chk("rst_flush", bus.flush, 0);
    chk("rst_excp_v", bus.excp_v, 0);
    chk("rst_flush_pc", bus.flush_pc, 0);
    chk("rst_excp_pc", bus.excp_pc, 0);
    tick();
    rst = 1'b0;
    bus.rob_vaild = 1'b0; bus.su_commit_ready = 1'b0;
    tick();
    chk("run_bru_ready", bus.bru_ready, 1);

    // Head-complete decode table
    for (int i = 0; i < 11; i++) begin
      head(vecs[i].vld, 64'h100 + 64'(i), vecs[i].rd, vecs[i].rn, vecs[i].br, vecs[i].su, 1'b0);
      set_wb(vecs[i].wb, vecs[i].rd, vecs[i].rn);
      bus.su_commit_ready = vecs[i].sur;
      #1;
      chk($sformatf("vec%0d_rob_ready", i), bus.rob_ready, vecs[i].exp_ready);
      chk($sformatf("vec%0d_su_commit_v", i), bus.su_commit_v, vecs[i].exp_su);
      if (vecs[i].exp_ready && vecs[i].rd != 0 && !vecs[i].su && !vecs[i].br)
        exp_q.push_back('{vecs[i].rd, vecs[i].rn});
      tick();
    end
    bus.rob_vaild = 1'b0; bus.su_commit_ready = 1'b0; bus.wbLog_qout = '0;
    tick();

    // Writeback stall then retire
    head(1'b1, 64'h200, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1; chk("wb_stall_rob_ready", bus.rob_ready, 0);
      tick();
    end
    set_wb(1, 5'd5, 2'd2);
    #1; chk("wb_ready_rob_ready", bus.rob_ready, 1);
    exp_q.push_back('{5'd5, 2'd2});
    tick();
    bus.rob_vaild = 1'b0;
    #1;
    chk("wb_commit_abi_v", bus.commit_abi_v, 1);
    chk("wb_commit_rd0", bus.commit_rd0, 5);
    chk("wb_commit_rn", bus.commit_rn, 2);
    tick();

    // Mispredicted branch: capture, pop, one-cycle flush
    head(1'b1, 64'h300, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    bus.bru_vaild = 1'b1; bus.bru_miss = 1'b1; bus.bru_target = 64'h8000_0100;
    #1;
    chk("br_bru_ready_free", bus.bru_ready, 1);
    chk("br_wait_rob_ready", bus.rob_ready, 0);
    tick();
    bus.bru_vaild = 1'b0;
    #1;
    chk("br_bru_ready_held", bus.bru_ready, 0);
    chk("br_pop", bus.rob_ready, 1);
    tick();
    bus.bru_vaild = 1'b1; bus.bru_miss = 1'b0; bus.bru_target = 64'hdead;
    #1;
    chk("br_flush", bus.flush, 1);
    chk("br_flush_pc", bus.flush_pc, 64'h8000_0100);
    chk("br_flush_rob_ready", bus.rob_ready, 0);
    chk("br_flush_no_commit", bus.commit_abi_v, 0);
    bus.rob_vaild = 1'b0;
    tick();
    bus.bru_vaild = 1'b0;
    #1;
    chk("br_after_flush", bus.flush, 0);
    chk("br_capture_killed", bus.bru_ready, 1);

    // Correctly predicted branch writing rd3
    head(1'b1, 64'h400, 5'd3, 2'd1, 1'b1, 1'b0, 1'b0);
    bus.bru_vaild = 1'b1; bus.bru_miss = 1'b0; bus.bru_target = 64'h404;
    tick();
    bus.bru_vaild = 1'b0;
    #1; chk("brok_pop", bus.rob_ready, 1);
    exp_q.push_back('{5'd3, 2'd1});
    tick();
    bus.rob_vaild = 1'b0;
    #1;
    chk("brok_no_flush", bus.flush, 0);
    chk("brok_commit", bus.commit_abi_v, 1);
    tick();

    // Store waiting on the LSU
    head(1'b1, 64'h500, 5'd7, 2'd0, 1'b0, 1'b1, 1'b0);
    bus.su_commit_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("st_wait_su_v", bus.su_commit_v, 1);
      chk("st_wait_rob_ready", bus.rob_ready, 0);
      tick();
    end
    bus.su_commit_ready = 1'b1;
    #1;
    chk("st_su_v", bus.su_commit_v, 1);
    chk("st_pop", bus.rob_ready, 1);
    tick();
    bus.rob_vaild = 1'b0; bus.su_commit_ready = 1'b0;
    #1; chk("st_no_commit", bus.commit_abi_v, 0);
    tick();

    // Illegal instruction (also flagged as store) traps and holds
    head(1'b1, 64'h1000, 5'd4, 2'd0, 1'b0, 1'b1, 1'b1);
    bus.su_commit_ready = 1'b1;
    #1;
    chk("ill_no_pop", bus.rob_ready, 0);
    chk("ill_no_su_v", bus.su_commit_v, 0);
    tick();
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("trap_excp_v", bus.excp_v, 1);
      chk("trap_excp_pc", bus.excp_pc, 64'h1000);
      chk("trap_rob_ready", bus.rob_ready, 0);
      tick();
    end
    bus.trap_ack = 1'b1;
    tick();
    bus.trap_ack = 1'b0; bus.rob_vaild = 1'b0; bus.su_commit_ready = 1'b0;
    #1;
    chk("trap_flush", bus.flush, 1);
    chk("trap_flush_pc", bus.flush_pc, 64'h1000);
    chk("trap_excp_clear", bus.excp_v, 0);
    tick();
    #1; chk("trap_back_run", bus.flush, 0);
    tick();

    // Asynchronous reset in the middle of TRAP
    head(1'b1, 64'h2000, 5'd4, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    bus.rob_vaild = 1'b0;
    #1; chk("rtrap_in_trap", bus.excp_v, 1);
    #1; rst = 1'b1;
    #1;
    chk("rtrap_excp_v", bus.excp_v, 0);
    chk("rtrap_excp_pc", bus.excp_pc, 0);
    chk("rtrap_flush_pc", bus.flush_pc, 0);
    chk("rtrap_bru_ready", bus.bru_ready, 0);
    chk("rtrap_commit", bus.commit_abi_v, 0);
    #1; rst = 1'b0;
    tick();
    head(1'b1, 64'h2100, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rtrap_resume_pop", bus.rob_ready, 1);
    chk("rtrap_resume_bru", bus.bru_ready, 1);
    tick();
    bus.rob_vaild = 1'b0;

    // Asynchronous reset in the middle of FLUSH
    head(1'b1, 64'h3000, 5'd4, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    bus.trap_ack = 1'b1; bus.rob_vaild = 1'b0;
    tick();
    bus.trap_ack = 1'b0;
    #1; chk("rflush_in_flush", bus.flush, 1);
    #1; rst = 1'b1;
    #1;
    chk("rflush_flush", bus.flush, 0);
    chk("rflush_flush_pc", bus.flush_pc, 0);
    chk("rflush_excp_pc", bus.excp_pc, 0);
    #1; rst = 1'b0;
    tick();
    #1;
    chk("rflush_resume_flush", bus.flush, 0);
    chk("rflush_resume_excp", bus.excp_v, 0);
    chk("rflush_resume_bru", bus.bru_ready, 1);

`ifdef COMMIT_INSTRET_EN
    chk("instret_reset", instret, 64'd0);
    head(1'b1, 64'h4000, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 100; k++) tick();
    bus.rob_vaild = 1'b0;
    #1; chk("instret_100", instret, 64'd100);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.instret_q;
    tick();
    bus.rob_vaild = 1'b1;
    tick();
    tick();
    bus.rob_vaild = 1'b0;
    #1; chk("instret_wrap", instret, 64'd0);
`endif

    tick();
    tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
